data_mem_bridge: RTL and testbench
==================================

Name: data_mem_bridge

Overview:
- Sits directly downstream of the single-cycle core's data-memory port.
- Consumes the core's combinational request (data_addr, should_read_mem, should_write_mem, mem_write_data) and converts it into a valid/ready request bus plus a separate read-response channel toward data memory.
- Returns mem_read_data to the core.
- Drives core_stall, which the core uses as its PC no_update, so one instruction is held until its memory access completes.

Parameters:
- ADDR_W, 32, address width of core and bus.
- DATA_W, 32, data width of core and bus.
- TIMEOUT, 255, maximum cycles spent in REQ+WAIT before a forced completion; counter width is clog2(TIMEOUT+1).
- ERR_RDATA, 32'hDEAD_BEEF, read data returned on timeout.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset.
- data_addr  in  ADDR_W  core access address.
- should_read_mem  in  1  core load request.
- should_write_mem  in  1  core store request.
- mem_write_data  in  DATA_W  core store data.
- mem_read_data  out  DATA_W  load result to core register-write mux.
- core_stall  out  1  hold core PC and register writes.
- bus_valid  out  1  request valid.
- bus_ready  in  1  request accepted.
- bus_write  out  1  1 = store, 0 = load.
- bus_addr  out  ADDR_W  request address.
- bus_wdata  out  DATA_W  store data.
- bus_rvalid  in  1  read response valid.
- bus_rdata  in  DATA_W  read response data.
- timeout_err  out  1  sticky; set on any timeout.

Behaviour:
- Reset (reset low, asynchronous): state=IDLE, bus_valid=0, bus_write=0, bus_addr=0, bus_wdata=0, mem_read_data=0, timeout counter=0, timeout_err=0.
- Reset mid-transaction drops bus_valid immediately and discards the latched request. The bus is responsible for discarding any outstanding response.
- FSM states: IDLE, REQ, WAIT, DONE.
- req = should_read_mem | should_write_mem. If both are high, the access is a store (write wins).
- core_stall (combinational) = (IDLE & req) | REQ | WAIT. It is 0 in DONE and when IDLE with no request.
- IDLE & req:
  - Latch addr, wdata and write into bus_* registers.
  - Clear the counter.
  - Go to REQ. bus_valid rises the cycle after the core presents the request.
- REQ:
  - bus_valid=1; bus_addr, bus_wdata and bus_write are held stable until bus_ready.
  - On bus_ready with write: go to DONE.
  - On bus_ready with read: go to WAIT. A bus_rvalid in the same cycle as bus_ready is ignored; the response must arrive at least 1 cycle later.
  - bus_valid drops in the cycle after acceptance.
- WAIT: bus_valid=0. On bus_rvalid, register bus_rdata into mem_read_data and go to DONE.
- DONE:
  - core_stall=0 for exactly one cycle; the core commits at this edge.
  - Unconditionally return to IDLE. The request visible in DONE is never re-issued.
  - mem_read_data holds its value until the next load completes; stores do not modify it.
- Timeout:
  - The counter increments each cycle in REQ or WAIT.
  - When it reaches TIMEOUT: go to DONE, force bus_valid=0, set mem_read_data=ERR_RDATA if the access is a load, and set timeout_err=1.
  - A late bus_rvalid arriving in IDLE or DONE is ignored.
- Latency, bus answering in 0 wait states:
  - Store: 3 cycles (IDLE, REQ, DONE).
  - Load: 4 cycles (IDLE, REQ, WAIT with rvalid, DONE).
- Back-to-back accesses: a new request is accepted in the IDLE cycle immediately following DONE.

Optional Feature:
- Macro: DATA_MEM_BRIDGE_ALIGN_CHECK_EN.
- Defined:
  - IDLE & req with data_addr[1:0]!=0 issues no bus transaction and goes directly to DONE.
  - A load returns mem_read_data=0; a store is dropped.
  - Adds output misaligned_err (1 bit, sticky, reset 0), which is set on such an access.
- Undefined: the address is forwarded verbatim, no alignment check is performed, and the misaligned_err port does not exist.

Test Plan:
- Store addr=0x100, data=0x12345678, bus_ready=1 in the first REQ cycle -> one bus_valid pulse with bus_write=1, bus_addr=0x100, bus_wdata=0x12345678; core_stall high for 2 cycles, then low for 1.
- Load addr=0x200, bus_ready after 3 REQ cycles, bus_rvalid 2 cycles later with 0xCAFEF00D -> bus_addr stable throughout REQ; mem_read_data=0xCAFEF00D in DONE; core_stall low exactly in DONE.
- Load with bus_ready never asserted, TIMEOUT=4 -> DONE after 4 REQ cycles, mem_read_data=0xDEAD_BEEF, timeout_err=1 and it stays 1 through subsequent good accesses.
- should_read_mem=should_write_mem=1 -> bus_write=1 (store issued). A spurious bus_rvalid in IDLE leaves mem_read_data unchanged.
- reset pulled low while in WAIT -> same-cycle bus_valid=0, state IDLE, all outputs 0; after release, a new load completes normally.
- With DATA_MEM_BRIDGE_ALIGN_CHECK_EN defined, load addr=0x203 -> no bus_valid, mem_read_data=0, misaligned_err=1; a subsequent aligned load at 0x204 succeeds.

Source files
------------

// File: rtl/data_mem_bridge.sv
// Data-memory bridge: turns the core's combinational load/store request into a valid/ready
// bus request plus read-response channel, stalling the core until the access completes.
// Optional DATA_MEM_BRIDGE_ALIGN_CHECK_EN: misaligned accesses complete locally and set misaligned_err.
module data_mem_bridge #(
   parameter int                ADDR_W    = 32,
   parameter int                DATA_W    = 32,
   parameter int                TIMEOUT   = 255,
   parameter logic [DATA_W-1:0] ERR_RDATA = 32'hDEAD_BEEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] data_addr,
   input  logic              should_read_mem,
   input  logic              should_write_mem,
   input  logic [DATA_W-1:0] mem_write_data,
   output logic [DATA_W-1:0] mem_read_data,
   output logic              core_stall,
   output logic              bus_valid,
   input  logic              bus_ready,
   output logic              bus_write,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [DATA_W-1:0] bus_wdata,
   input  logic              bus_rvalid,
   input  logic [DATA_W-1:0] bus_rdata,
`ifdef DATA_MEM_BRIDGE_ALIGN_CHECK_EN
   output logic              misaligned_err,
`endif
   output logic              timeout_err
);

   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   state_t        state_r;
   state_t        next_state_s;
   logic [CW-1:0] cnt_r;
   logic          req_s;
   logic          mis_s;
   logic          mis_load_s;
   logic          tmo_s;
   logic          force_tmo_s;
   logic          start_s;

   // Next-state decode, timeout detection and the combinational core stall.
   always_comb begin
      req_s = should_read_mem | should_write_mem;
`ifdef DATA_MEM_BRIDGE_ALIGN_CHECK_EN
      mis_s = req_s & (data_addr[1:0] != 2'b00);
`else
      mis_s = 1'b0;
`endif
      tmo_s        = (cnt_r >= CW'(TIMEOUT - 1));
      start_s      = 1'b0;
      force_tmo_s  = 1'b0;
      mis_load_s   = 1'b0;
      next_state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (mis_s) begin
               next_state_s = ST_DONE;
               mis_load_s   = ~should_write_mem;
            end else if (req_s) begin
               next_state_s = ST_REQ;
               start_s      = 1'b1;
            end else begin
               next_state_s = ST_IDLE;
            end
         end
         ST_REQ: begin
            // A read accepted on the last allowed cycle can no longer get its data in time.
            if (bus_ready && bus_write) begin
               next_state_s = ST_DONE;
            end else if (tmo_s) begin
               next_state_s = ST_DONE;
               force_tmo_s  = 1'b1;
            end else if (bus_ready) begin
               next_state_s = ST_WAIT;
            end else begin
               next_state_s = ST_REQ;
            end
         end
         ST_WAIT: begin
            if (bus_rvalid) begin
               next_state_s = ST_DONE;
            end else if (tmo_s) begin
               next_state_s = ST_DONE;
               force_tmo_s  = 1'b1;
            end else begin
               next_state_s = ST_WAIT;
            end
         end
         ST_DONE: next_state_s = ST_IDLE;
         default: next_state_s = ST_IDLE;
      endcase
      core_stall = ((state_r == ST_IDLE) & req_s) | (state_r == ST_REQ) | (state_r == ST_WAIT);
   end

   // State, bus request registers, timeout counter and load result.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r       <= ST_IDLE;
         bus_valid     <= 1'b0;
         bus_write     <= 1'b0;
         bus_addr      <= '0;
         bus_wdata     <= '0;
         mem_read_data <= '0;
         cnt_r         <= '0;
         timeout_err   <= 1'b0;
      end else begin
         state_r   <= next_state_s;
         bus_valid <= (next_state_s == ST_REQ);
         if (start_s) begin
            bus_addr  <= data_addr;
            bus_wdata <= mem_write_data;
            bus_write <= should_write_mem;
            cnt_r     <= '0;
         end else if ((state_r == ST_REQ) || (state_r == ST_WAIT)) begin
            cnt_r <= cnt_r + CW'(1);
         end
         if ((state_r == ST_WAIT) && bus_rvalid) begin
            mem_read_data <= bus_rdata;
         end else if (force_tmo_s && !bus_write) begin
            mem_read_data <= ERR_RDATA;
         end else if (mis_load_s) begin
            mem_read_data <= '0;
         end
         if (force_tmo_s) begin
            timeout_err <= 1'b1;
         end
      end
   end

`ifdef DATA_MEM_BRIDGE_ALIGN_CHECK_EN
   // Sticky flag for accesses rejected by the alignment check.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         misaligned_err <= 1'b0;
      end else if ((state_r == ST_IDLE) && mis_s) begin
         misaligned_err <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_data_mem_bridge.sv
// Bench for data_mem_bridge: directed and randomized core accesses, a transaction-level
// reference model feeding a scoreboard queue, and a monitor checking every completed access.
`timescale 1ns/1ps
module tb_data_mem_bridge;

   localparam int          TMO = 8;
   localparam logic [31:0] ERR = 32'hDEAD_BEEF;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] data_addr;
   logic        should_read_mem;
   logic        should_write_mem;
   logic [31:0] mem_write_data;
   logic [31:0] mem_read_data;
   logic        core_stall;
   logic        bus_valid;
   logic        bus_ready;
   logic        bus_write;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic        bus_rvalid;
   logic [31:0] bus_rdata;
   logic        timeout_err;
`ifdef DATA_MEM_BRIDGE_ALIGN_CHECK_EN
   logic        misaligned_err;
   logic        m_merr = 1'b0;
`endif

   always #5 clk = ~clk;

   data_mem_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO), .ERR_RDATA(ERR)) dut (
      .clk(clk),
      .reset(reset),
      .data_addr(data_addr),
      .should_read_mem(should_read_mem),
      .should_write_mem(should_write_mem),
      .mem_write_data(mem_write_data),
      .mem_read_data(mem_read_data),
      .core_stall(core_stall),
      .bus_valid(bus_valid),
      .bus_ready(bus_ready),
      .bus_write(bus_write),
      .bus_addr(bus_addr),
      .bus_wdata(bus_wdata),
      .bus_rvalid(bus_rvalid),
      .bus_rdata(bus_rdata),
`ifdef DATA_MEM_BRIDGE_ALIGN_CHECK_EN
      .misaligned_err(misaligned_err),
`endif
      .timeout_err(timeout_err)
   );

   typedef struct {
      int          stall_len;
      int          accepts;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic        terr;
      logic        merr;
   } exp_t;

   exp_t        sb_q[$];
   int          checks = 0;
   int          errors = 0;
   logic [31:0] m_rdata = 32'd0;
   logic        m_terr = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // One core access: model the outcome, queue it, then drive the core and bus sides.
   // dr = REQ cycles before bus_ready, dv = cycles from acceptance to bus_rvalid.
   task automatic do_tx(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                        input int dr, input int dv, input logic [31:0] rdat);
      exp_t e;
      int   n;
      int   nexp;
      logic tmo;
      logic mis;
      mis = 1'b0;
`ifdef DATA_MEM_BRIDGE_ALIGN_CHECK_EN
      mis = (addr[1:0] != 2'b00);
`endif
      n = wr ? (dr + 1) : (dr + 1 + dv);
      if (mis) begin
         nexp = 0;
         tmo  = 1'b0;
      end else if (n > TMO) begin
         nexp = TMO;
         tmo  = 1'b1;
      end else begin
         nexp = n;
         tmo  = 1'b0;
      end
      if (mis) begin
`ifdef DATA_MEM_BRIDGE_ALIGN_CHECK_EN
         m_merr = 1'b1;
`endif
         if (!wr) m_rdata = 32'd0;
      end else if (tmo) begin
         m_terr = 1'b1;
         if (!wr) m_rdata = ERR;
      end else if (!wr) begin
         m_rdata = rdat;
      end
      e.stall_len = 1 + nexp;
      e.accepts   = (!mis && (dr + 1 <= TMO)) ? 1 : 0;
      e.wr        = wr;
      e.addr      = addr;
      e.wdata     = wd;
      e.rdata     = m_rdata;
      e.terr      = m_terr;
      e.merr      = 1'b0;
`ifdef DATA_MEM_BRIDGE_ALIGN_CHECK_EN
      e.merr      = m_merr;
`endif
      sb_q.push_back(e);

      should_read_mem  = rd;
      should_write_mem = wr;
      data_addr        = addr;
      mem_write_data   = wd;
      bus_ready        = 1'b0;
      bus_rvalid       = 1'b0;
      for (int c = 1; c <= nexp; c++) begin
         @(posedge clk); #1;
         bus_ready  = (c == dr + 1);
         bus_rvalid = !wr && ((c == dr + 1 + dv) || ((c == dr + 1) && 1'($urandom_range(0, 1))));
         bus_rdata  = (c == dr + 1 + dv) ? rdat : $urandom;
      end
      @(posedge clk); #1;
      bus_ready  = 1'b0;
      bus_rvalid = 1'($urandom_range(0, 1));
      bus_rdata  = $urandom;
      @(posedge clk); #1;
      should_read_mem  = 1'b0;
      should_write_mem = 1'b0;
      bus_rvalid       = 1'b0;
   endtask

   // Monitor: completion is the cycle core_stall falls; compare it with the oldest expectation.
   initial begin : monitor
      int          stall_len = 0;
      int          acc_n = 0;
      logic        prev_stall = 1'b0;
      logic        prev_valid = 1'b0;
      logic [31:0] hold_addr = 32'd0;
      logic [31:0] acc_addr = 32'd0;
      logic [31:0] acc_wdata = 32'd0;
      logic        acc_wr = 1'b0;
      exp_t        e;
      forever begin
         @(negedge clk);
         if (!reset) begin
            stall_len  = 0;
            acc_n      = 0;
            prev_stall = 1'b0;
            prev_valid = 1'b0;
         end else begin
            if (bus_valid) begin
               if (prev_valid) chk("addr_stable", bus_addr, hold_addr);
               else hold_addr = bus_addr;
               if (bus_ready) begin
                  acc_n++;
                  acc_addr  = bus_addr;
                  acc_wdata = bus_wdata;
                  acc_wr    = bus_write;
               end
            end
            prev_valid = bus_valid;
            if (core_stall) begin
               stall_len++;
            end else if (prev_stall) begin
               if (sb_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_done: completion seen with empty scoreboard at %0t", $time);
               end else begin
                  e = sb_q.pop_front();
                  chk("stall_len", stall_len, e.stall_len);
                  chk("bus_accepts", acc_n, e.accepts);
                  if (e.accepts == 1) begin
                     chk("bus_addr", acc_addr, e.addr);
                     chk("bus_write", 32'(acc_wr), 32'(e.wr));
                     chk("bus_wdata", acc_wdata, e.wdata);
                  end
                  chk("mem_read_data", mem_read_data, e.rdata);
                  chk("timeout_err", 32'(timeout_err), 32'(e.terr));
                  chk("valid_in_done", 32'(bus_valid), 32'd0);
`ifdef DATA_MEM_BRIDGE_ALIGN_CHECK_EN
                  chk("misaligned_err", 32'(misaligned_err), 32'(e.merr));
`endif
               end
               stall_len = 0;
               acc_n     = 0;
            end
            prev_stall = core_stall;
         end
      end
   end

   initial begin : stim
      logic        r;
      logic        w;
      logic [31:0] a;
      int          gap;
      reset            = 1'b0;
      data_addr        = 32'd0;
      should_read_mem  = 1'b0;
      should_write_mem = 1'b0;
      mem_write_data   = 32'd0;
      bus_ready        = 1'b0;
      bus_rvalid       = 1'b0;
      bus_rdata        = 32'd0;
      #3;
      chk("rst_valid", 32'(bus_valid), 32'd0);
      chk("rst_write", 32'(bus_write), 32'd0);
      chk("rst_addr", bus_addr, 32'd0);
      chk("rst_wdata", bus_wdata, 32'd0);
      chk("rst_rdata", mem_read_data, 32'd0);
      chk("rst_stall", 32'(core_stall), 32'd0);
      chk("rst_terr", 32'(timeout_err), 32'd0);
      @(negedge clk); #1 reset = 1'b1;
      @(posedge clk); #1;

      do_tx(1'b0, 1'b1, 32'h100, 32'h12345678, 0, 1, 32'd0);
      do_tx(1'b1, 1'b0, 32'h200, 32'h0, 3, 2, 32'hCAFEF00D);
      do_tx(1'b1, 1'b0, 32'h300, 32'h0, 100, 1, 32'h11111111);
      do_tx(1'b1, 1'b0, 32'h304, 32'h0, 0, 1, 32'h22222222);
      do_tx(1'b1, 1'b1, 32'h308, 32'hA5A5A5A5, 1, 1, 32'h33333333);

      // Stray read responses while idle must not touch the load result.
      repeat (2) begin
         bus_rvalid = 1'b1;
         bus_rdata  = 32'h55AA55AA;
         @(posedge clk); #1;
      end
      bus_rvalid = 1'b0;
      chk("idle_rvalid_ignored", mem_read_data, m_rdata);

      for (int i = 0; i < 30; i++) begin
         r = 1'($urandom_range(0, 1));
         w = 1'($urandom_range(0, 1));
         if (!r && !w) r = 1'b1;
         a = $urandom;
`ifdef DATA_MEM_BRIDGE_ALIGN_CHECK_EN
         a[1:0] = 2'b00;
`endif
         do_tx(r, w, a, $urandom, $urandom_range(0, 9), $urandom_range(1, 4), $urandom);
         gap = $urandom_range(0, 2);
         repeat (gap) begin
            bus_rvalid = 1'($urandom_range(0, 1));
            bus_rdata  = $urandom;
            @(posedge clk); #1;
         end
         bus_rvalid = 1'b0;
      end

      // Reset while waiting for read data.
      should_read_mem = 1'b1;
      data_addr       = 32'h400;
      @(posedge clk); #1;
      bus_ready = 1'b1;
      @(posedge clk); #1;
      bus_ready = 1'b0;
      #2;
      reset           = 1'b0;
      should_read_mem = 1'b0;
      #1;
      chk("midrst_valid", 32'(bus_valid), 32'd0);
      chk("midrst_stall", 32'(core_stall), 32'd0);
      chk("midrst_rdata", mem_read_data, 32'd0);
      chk("midrst_addr", bus_addr, 32'd0);
      chk("midrst_wdata", bus_wdata, 32'd0);
      chk("midrst_write", 32'(bus_write), 32'd0);
      chk("midrst_terr", 32'(timeout_err), 32'd0);
      m_rdata = 32'd0;
      m_terr  = 1'b0;
`ifdef DATA_MEM_BRIDGE_ALIGN_CHECK_EN
      chk("midrst_merr", 32'(misaligned_err), 32'd0);
      m_merr = 1'b0;
`endif
      @(negedge clk); #1 reset = 1'b1;
      @(posedge clk); #1;

      do_tx(1'b1, 1'b0, 32'h400, 32'h0, 1, 2, 32'h0BADF00D);
      do_tx(1'b1, 1'b0, 32'h203, 32'h0, 0, 1, 32'h44444444);
      do_tx(1'b1, 1'b0, 32'h204, 32'h0, 0, 1, 32'h66666666);
      do_tx(1'b0, 1'b1, 32'h208, 32'h77777777, 2, 1, 32'd0);

      repeat (3) @(posedge clk);
      #1;
      chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
